// File: rtl/common_ram_bist.sv
`default_nettype none
// ============================================================================
//  Module   : common_ram_bist
//  Purpose  : March C- built-in self-test sequencer for a single-port
//             synchronous RAM. Drives address, write data and enables, checks
//             read data one cycle after each read, and reports a sticky
//             pass/fail flag plus the address of the first mismatch.
//  Ports    : clk          rising-edge clock
//             rst          asynchronous, active-high reset
//             i_start      level-sampled start request (ignored while busy)
//             i_ram_rdata  RAM read data, valid one cycle after a read
//             o_ram_addr   RAM address (registered)
//             o_ram_wdata  RAM write data (registered, 0 on reads)
//             o_ram_ce     RAM chip enable (registered)
//             o_ram_we     RAM write enable, 1 = write (registered)
//             o_busy       test in progress
//             o_done       test complete, held until the next accepted start
//             o_fail       sticky mismatch flag
//             o_fail_addr  address of the first mismatch
//  Revision : 1.0 - initial release
// ============================================================================
module common_ram_bist #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic              o_ram_ce,
    output logic              o_ram_we,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_fail,
    output logic [ADDR_W-1:0] o_fail_addr
);

    localparam logic [ADDR_W-1:0] c_ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_M0    = 4'd1,
        S_M1    = 4'd2,
        S_M2    = 4'd3,
        S_M3    = 4'd4,
        S_M4    = 4'd5,
        S_M5    = 4'd6,
        S_FLUSH = 4'd7,
        S_FIN   = 4'd8
    } state_t;

    // ------------------------------------------------------------------
    // March element attributes
    // ------------------------------------------------------------------
    function automatic logic f_is_march(input state_t s);
        return (s == S_M0) || (s == S_M1) || (s == S_M2) ||
               (s == S_M3) || (s == S_M4) || (s == S_M5);
    endfunction

    // Elements M1..M4 are read-then-write on the same address
    function automatic logic f_two_op(input state_t s);
        return (s == S_M1) || (s == S_M2) || (s == S_M3) || (s == S_M4);
    endfunction

    // Only M3 and M4 walk the address space downwards
    function automatic logic f_up(input state_t s);
        return !((s == S_M3) || (s == S_M4));
    endfunction

    // Background written by the element (M0 is w0)
    function automatic logic f_wr_bg(input state_t s);
        return (s == S_M1) || (s == S_M3);
    endfunction

    // Background expected on reads of the element
    function automatic logic f_rd_bg(input state_t s);
        return (s == S_M2) || (s == S_M4);
    endfunction

    function automatic state_t f_next_elem(input state_t s);
        case (s)
            S_M0:    return S_M1;
            S_M1:    return S_M2;
            S_M2:    return S_M3;
            S_M3:    return S_M4;
            S_M4:    return S_M5;
            S_M5:    return S_FLUSH;
            default: return S_IDLE;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_phase;       // 0 = read slot, 1 = write slot
    logic              r_ce;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_cmp_valid;
    logic [DATA_W-1:0] r_cmp_exp;
    logic [ADDR_W-1:0] r_cmp_addr;
    logic              r_fail;
    logic [ADDR_W-1:0] r_fail_addr;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_phase_nxt;
    logic              w_ce_nxt;
    logic              w_we_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_start_acc;
    logic              w_last_op;
    logic              w_rd_issue;
    logic              w_mismatch;

    // ------------------------------------------------------------------
    // Next-state and next-output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_phase_nxt = r_phase;
        w_start_acc = 1'b0;
        w_last_op   = 1'b0;

        case (r_state)
            S_IDLE, S_FIN: begin
                if (i_start) begin
                    w_state_nxt = S_M0;
                    w_addr_nxt  = '0;
                    w_phase_nxt = 1'b0;
                    w_start_acc = 1'b1;
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_FIN;
            end
            default: begin
                w_last_op = !f_two_op(r_state) || r_phase;
                if (!w_last_op) begin
                    w_phase_nxt = 1'b1;
                end else begin
                    w_phase_nxt = 1'b0;
                    if (r_addr == (f_up(r_state) ? c_ADDR_MAX : '0)) begin
                        // Element finished: reload address for the next one.
                        // FLUSH counts as "up" so the bus returns to 0.
                        w_state_nxt = f_next_elem(r_state);
                        w_addr_nxt  = f_up(f_next_elem(r_state)) ? '0 : c_ADDR_MAX;
                    end else if (f_up(r_state)) begin
                        w_addr_nxt = r_addr + c_ADDR_ONE;
                    end else begin
                        w_addr_nxt = r_addr - c_ADDR_ONE;
                    end
                end
            end
        endcase

        // Bus outputs are decoded from the next state so they are registered
        // in step with it.
        w_ce_nxt    = f_is_march(w_state_nxt);
        w_we_nxt    = w_ce_nxt &&
                      ((w_state_nxt == S_M0) || (f_two_op(w_state_nxt) && w_phase_nxt));
        w_wdata_nxt = w_we_nxt ? {DATA_W{f_wr_bg(w_state_nxt)}} : '0;
        w_busy_nxt  = w_ce_nxt || (w_state_nxt == S_FLUSH);
        w_done_nxt  = (w_state_nxt == S_FIN);

        w_rd_issue  = r_ce && !r_we;
        w_mismatch  = r_cmp_valid && (i_ram_rdata != r_cmp_exp);
    end

    // ------------------------------------------------------------------
    // State, bus and compare registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_phase     <= 1'b0;
            r_ce        <= 1'b0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cmp_valid <= 1'b0;
            r_cmp_exp   <= '0;
            r_cmp_addr  <= '0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_phase     <= w_phase_nxt;
            r_ce        <= w_ce_nxt;
            r_we        <= w_we_nxt;
            r_wdata     <= w_wdata_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;

            // Capture the read on the bus; its data returns next cycle
            r_cmp_valid <= w_rd_issue;
            r_cmp_exp   <= {DATA_W{f_rd_bg(r_state)}};
            r_cmp_addr  <= r_addr;

            if (w_start_acc) begin
                r_fail      <= 1'b0;
                r_fail_addr <= '0;
            end else if (w_mismatch) begin
                r_fail <= 1'b1;
                if (!r_fail) begin
                    r_fail_addr <= r_cmp_addr;
                end
            end
        end
    end

    assign o_ram_addr  = r_addr;
    assign o_ram_wdata = r_wdata;
    assign o_ram_ce    = r_ce;
    assign o_ram_we    = r_we;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_fail      = r_fail;
    assign o_fail_addr = r_fail_addr;

endmodule
`default_nettype wire

// File: tb/tb_common_ram_bist.sv
`default_nettype none
// ============================================================================
//  Module   : tb_common_ram_bist
//  Purpose  : Directed self-checking bench for common_ram_bist with a
//             behavioural single-port RAM that supports per-address
//             stuck-at masks on the read path.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_common_ram_bist;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int N      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic [DATA_W-1:0] i_ram_rdata;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [DATA_W-1:0] o_ram_wdata;
    logic              o_ram_ce;
    logic              o_ram_we;
    logic              o_busy;
    logic              o_done;
    logic              o_fail;
    logic [ADDR_W-1:0] o_fail_addr;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] mem   [N];
    logic [DATA_W-1:0] and_m [N];
    logic [DATA_W-1:0] or_m  [N];

    common_ram_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_ram_rdata (i_ram_rdata),
        .o_ram_addr  (o_ram_addr),
        .o_ram_wdata (o_ram_wdata),
        .o_ram_ce    (o_ram_ce),
        .o_ram_we    (o_ram_we),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_fail      (o_fail),
        .o_fail_addr (o_fail_addr)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM; faults applied on the read path
    always @(posedge clk) begin
        if (o_ram_ce) begin
            if (o_ram_we) begin
                mem[o_ram_addr] <= o_ram_wdata;
            end else begin
                i_ram_rdata <= (mem[o_ram_addr] & and_m[o_ram_addr]) | or_m[o_ram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < N; i++) begin
            and_m[i] = '1;
            or_m[i]  = '0;
        end
    endtask

    // Called at #1 after an edge (that cycle is cycle 0). Runs through cycle
    // 162 and leaves the bench sampling in cycle 162.
    task automatic do_run(input bit hold, input int exp_rise, input logic [ADDR_W-1:0] exp_fa);
        int ce_cnt;
        int rise;
        ce_cnt = 0;
        rise   = -1;
        i_start = 1'b1;
        @(posedge clk); #1;
        if (!hold) i_start = 1'b0;
        chk("fail_cleared_c1", {31'd0, o_fail}, 32'd0);
        for (int c = 1; c <= 10*N + 2; c++) begin
            if (o_ram_ce) ce_cnt++;
            if (o_fail && rise < 0) rise = c;
            if (c == 1 || c == 10*N + 1 || c == 10*N + 2) begin
                chk($sformatf("busy_c%0d", c), {31'd0, o_busy}, {31'd0, (c <= 10*N + 1)});
                chk($sformatf("done_c%0d", c), {31'd0, o_done}, {31'd0, (c >= 10*N + 2)});
            end
            if (c <= N) begin
                chk($sformatf("m0_bus_c%0d", c), {18'd0, o_ram_ce, o_ram_we, o_ram_wdata, o_ram_addr},
                    {18'd0, 1'b1, 1'b1, 8'h00, 4'(c - 1)});
            end
            if (c == 17) chk("m1_read_c17", {18'd0, o_ram_ce, o_ram_we, o_ram_wdata, o_ram_addr}, {18'd0, 2'b10, 8'h00, 4'd0});
            if (c == 18) chk("m1_write_c18", {18'd0, o_ram_ce, o_ram_we, o_ram_wdata, o_ram_addr}, {18'd0, 2'b11, 8'hFF, 4'd0});
            if (c == 113) chk("m4_read_c113", {18'd0, o_ram_ce, o_ram_we, o_ram_wdata, o_ram_addr}, {18'd0, 2'b10, 8'h00, 4'd15});
            if (c == 161) chk("flush_bus_c161", {18'd0, o_ram_ce, o_ram_we, o_ram_wdata, o_ram_addr}, 32'd0);
            if (c < 10*N + 2) begin
                @(posedge clk); #1;
            end
        end
        chk("ce_cycles", ce_cnt, 10*N);
        chk("fail_rise_cycle", rise, exp_rise);
        chk("fail_final", {31'd0, o_fail}, {31'd0, (exp_rise > 0)});
        chk("fail_addr", {28'd0, o_fail_addr}, {28'd0, exp_fa});
    endtask

    initial begin
        for (int i = 0; i < N; i++) mem[i] = '0;
        clear_faults();
        i_ram_rdata = '0;
        i_start = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {o_ram_addr, o_ram_wdata, o_ram_ce, o_ram_we, o_busy, o_done, o_fail, o_fail_addr}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_start_busy", {31'd0, o_busy}, 32'd0);

        // 1: ideal RAM, single-cycle start pulse
        do_run(1'b0, -1, 4'd0);

        // 2: bit 0 stuck-at-1 at address 5, restarted from FIN
        or_m[5] = 8'h01;
        do_run(1'b0, 29, 4'd5);

        // 3: two faults; the earlier-detected address 3 must win
        clear_faults();
        and_m[9] = 8'h7F;
        or_m[3]  = 8'h04;
        do_run(1'b0, 25, 4'd3);
        clear_faults();

        // 4: reset mid-run at cycle 50
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (49) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_busy", {31'd0, o_busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", {o_ram_addr, o_ram_wdata, o_ram_ce, o_ram_we, o_busy, o_done, o_fail, o_fail_addr}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("post_rst_idle", {30'd0, o_busy, o_ram_ce}, 32'd0);
        do_run(1'b0, -1, 4'd0);

        // 5: start held high with a fault -> back-to-back runs
        or_m[5] = 8'h01;
        do_run(1'b1, 29, 4'd5);
        clear_faults();
        @(posedge clk); #1;
        chk("restart_busy", {31'd0, o_busy}, 32'd1);
        chk("restart_done_low", {31'd0, o_done}, 32'd0);
        chk("restart_fail_cleared", {27'd0, o_fail, o_fail_addr}, 32'd0);
        chk("restart_bus", {18'd0, o_ram_ce, o_ram_we, o_ram_wdata, o_ram_addr}, {18'd0, 2'b11, 8'h00, 4'd0});
        i_start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
